bram2_port_arbiter: RTL and testbench

- Shares one port of the dual-ported write-first BRAM (BRAM2) between two requesters, e.g. an instruction fetch and a debug/DMA master.
- Each requester gets a valid/ready request channel and a valid/ready read-response channel.
- Arbitration is round-robin.
- The block tracks the BRAM read latency, which depends on PIPELINED, and steers each read result back to the requester that issued it.
- Per-requester response FIFOs with credit-based issue ensure no read data is ever dropped under response backpressure.

---
 rtl/bram2_port_arbiter.sv | 99 +++++++++
 tb/tb_bram2_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram2_port_arbiter.sv
// bram2_port_arbiter: round-robin sharing of one BRAM2 port between two requesters,
// steering read data back through credit-protected per-requester response FIFOs.
module bram2_port_arbiter #(
  parameter int PIPELINED  = 0,
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout
);
  localparam int LAT = 1 + PIPELINED;
  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int PW  = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
  logic [1:0] req_valid, req_write, rsp_ready, rsp_valid, elig, grant, rd_acc, push, pop;
  logic [ADDR_WIDTH-1:0] req_addr [2];
  logic [DATA_WIDTH-1:0] req_wdata [2];
  logic [DATA_WIDTH-1:0] rsp_rdata [2];
  logic ptr;
  logic [LAT-1:0] tag_v, tag_id;
  assign req_valid    = {req1_valid, req0_valid};
  assign req_write    = {req1_write, req0_write};
  assign rsp_ready    = {rsp1_ready, rsp0_ready};
  assign req_addr[0]  = req0_addr;
  assign req_addr[1]  = req1_addr;
  assign req_wdata[0] = req0_wdata;
  assign req_wdata[1] = req1_wdata;
  // ptr names the requester that wins when both are eligible
  assign grant[0] = !RST && elig[0] && (!elig[1] || !ptr);
  assign grant[1] = !RST && elig[1] && (!elig[0] || ptr);
  assign rd_acc   = grant & ~req_write;
  assign push     = {tag_v[LAT-1] & tag_id[LAT-1], tag_v[LAT-1] & ~tag_id[LAT-1]};
  assign pop      = rsp_valid & rsp_ready;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_rdata = rsp_rdata[0];
  assign rsp1_rdata = rsp_rdata[1];
  assign bram_en   = |grant;
  assign bram_we   = |(grant & req_write);
  assign bram_addr = grant[1] ? req_addr[1] : grant[0] ? req_addr[0] : '0;
  assign bram_din  = grant[1] ? req_wdata[1] : grant[0] ? req_wdata[0] : '0;
  // Tag shift register: bit 0 is the newest accept, bit LAT-1 lines up with valid bram_dout
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      ptr    <= 1'b0;
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      if (|grant) ptr <= grant[0];
      tag_v  <= LAT'({tag_v, |rd_acc});
      tag_id <= LAT'({tag_id, rd_acc[1]});
    end
  for (genvar i = 0; i < 2; i++) begin : g_rsp
    logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt, credit;
    assign elig[i]      = req_valid[i] && (req_write[i] || credit != '0);
    assign rsp_valid[i] = cnt != '0;
    assign rsp_rdata[i] = mem[rp];
    always_ff @(posedge CLK)
      if (push[i]) mem[wp] <= bram_dout;
    // credit + in-flight + occupancy stays at RSP_DEPTH, so a push always finds room
    always_ff @(posedge CLK or posedge RST)
      if (RST) begin
        wp     <= '0;
        rp     <= '0;
        cnt    <= '0;
        credit <= CW'(RSP_DEPTH);
      end else begin
        if (push[i]) wp <= wp == PW'(RSP_DEPTH - 1) ? '0 : wp + 1'b1;
        if (pop[i]) rp <= rp == PW'(RSP_DEPTH - 1) ? '0 : rp + 1'b1;
        cnt    <= cnt + CW'(push[i]) - CW'(pop[i]);
        credit <= credit + CW'(pop[i]) - CW'(rd_acc[i]);
      end
  end
endmodule

// File: tb/tb_bram2_port_arbiter.sv
// tb_bram2_port_arbiter: directed checks of the arbiter with PIPELINED=0 (u_a) and
// PIPELINED=1 (u_b) instances, each driving its own write-first BRAM model.
module tb_bram2_port_arbiter;
  logic CLK = 1'b0;
  logic RST;
  logic req0_valid, req0_write, rsp0_ready, req1_valid, req1_write, rsp1_ready;
  logic [7:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_en, a_we;
  logic b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_en, b_we;
  logic [7:0] a_rsp0_rdata, a_rsp1_rdata, a_addr, a_din, a_dout;
  logic [7:0] b_rsp0_rdata, b_rsp1_rdata, b_addr, b_din, b_dout, b_q1;
  logic [7:0] ma [256];
  logic [7:0] mb [256];
  logic [7:0] exp_mem [256];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  bram2_port_arbiter #(.PIPELINED(0), .ADDR_WIDTH(8), .DATA_WIDTH(8), .RSP_DEPTH(2)) u_a (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(a_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(a_rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(a_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(a_rsp1_rdata),
    .bram_en(a_en), .bram_we(a_we), .bram_addr(a_addr), .bram_din(a_din), .bram_dout(a_dout));

  bram2_port_arbiter #(.PIPELINED(1), .ADDR_WIDTH(8), .DATA_WIDTH(8), .RSP_DEPTH(2)) u_b (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(b_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(b_rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(b_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(b_rsp1_rdata),
    .bram_en(b_en), .bram_we(b_we), .bram_addr(b_addr), .bram_din(b_din), .bram_dout(b_dout));

  always @(posedge CLK)
    if (a_en) begin
      if (a_we) begin
        ma[a_addr] <= a_din;
        a_dout <= a_din;
      end else a_dout <= ma[a_addr];
    end

  always @(posedge CLK) begin
    if (b_en) begin
      if (b_we) begin
        mb[b_addr] <= b_din;
        b_q1 <= b_din;
      end else b_q1 <= mb[b_addr];
    end
    b_dout <= b_q1;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 8'h00; req0_wdata = 8'h00;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 8'h00; req1_wdata = 8'h00;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic write1(input logic [7:0] addr, input logic [7:0] data);
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = addr; req1_wdata = data;
    exp_mem[addr] = data;
    tick();
    req1_valid = 1'b0; req1_write = 1'b0;
  endtask

  task automatic test_reset;
    idle();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    RST = 1'b1;
    req0_valid = 1'b1; req0_addr = 8'h05;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 8'h09;
    tick();
    tick();
    checks++; if (a_req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready: got %b want 0", a_req0_ready); end
    checks++; if (a_req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready: got %b want 0", a_req1_ready); end
    checks++; if (a_en !== 1'b0 || a_we !== 1'b0) begin errors++; $display("FAIL reset_bram_en_we: got %b%b want 00", a_en, a_we); end
    checks++; if (a_addr !== 8'h00 || a_din !== 8'h00) begin errors++; $display("FAIL reset_bram_addr_din: got %h %h want 00 00", a_addr, a_din); end
    checks++; if (a_rsp0_valid !== 1'b0 || a_rsp1_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b%b want 00", a_rsp0_valid, a_rsp1_valid); end
    checks++; if (b_en !== 1'b0 || b_rsp0_valid !== 1'b0) begin errors++; $display("FAIL reset_pipe_en_valid: got %b%b want 00", b_en, b_rsp0_valid); end
    idle();
    RST = 1'b0;
    tick();
  endtask

  task automatic test_single_read;
    for (int i = 0; i < 32; i++) write1(8'(i), 8'(i * 13) ^ 8'h5A);
    write1(8'h05, 8'hA5);
    write1(8'h07, 8'h3C);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 8'h05;
    #1;
    checks++; if (a_req0_ready !== 1'b1 || b_req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b %b want 1 1", a_req0_ready, b_req0_ready); end
    checks++; if (a_en !== 1'b1 || a_we !== 1'b0 || a_addr !== 8'h05) begin errors++; $display("FAIL single_bram_drive: got en=%b we=%b addr=%h want 1 0 05", a_en, a_we, a_addr); end
    tick();
    req0_valid = 1'b0;
    checks++; if (a_rsp0_valid !== 1'b0 || b_rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b %b want 0 0", a_rsp0_valid, b_rsp0_valid); end
    tick();
    checks++; if (a_rsp0_valid !== 1'b1 || a_rsp0_rdata !== 8'hA5) begin errors++; $display("FAIL single_lat2_rsp: got %b %h want 1 a5", a_rsp0_valid, a_rsp0_rdata); end
    checks++; if (b_rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_pipe_early: got %b want 0", b_rsp0_valid); end
    tick();
    checks++; if (a_rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_after_pop: got %b want 0", a_rsp0_valid); end
    checks++; if (b_rsp0_valid !== 1'b1 || b_rsp0_rdata !== 8'hA5) begin errors++; $display("FAIL single_lat3_rsp: got %b %h want 1 a5", b_rsp0_valid, b_rsp0_rdata); end
    tick();
    checks++; if (b_rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_pipe_after_pop: got %b want 0", b_rsp0_valid); end
  endtask

  task automatic test_round_robin;
    int n0, n1, got0, got1;
    logic e;
    n0 = 0; n1 = 0; got0 = 0; got1 = 0;
    q0.delete(); q1.delete();
    idle();
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int c = 0; c < 104; c++) begin
      req0_valid = c < 100; req0_addr = 8'(n0 % 32);
      req1_valid = c < 100; req1_addr = 8'((n1 + 16) % 32);
      #1;
      if (c < 100) begin
        e = (c % 2 == 0);
        checks++; if (a_req0_ready !== e || a_req1_ready !== !e) begin errors++; $display("FAIL rr_grant c=%0d: got %b%b want %b%b", c, a_req1_ready, a_req0_ready, !e, e); end
      end
      if (a_rsp0_valid) begin
        checks++;
        if (q0.size() == 0 || a_rsp0_rdata !== q0[0]) begin errors++; $display("FAIL rr_rsp0 c=%0d: got %h want %h", c, a_rsp0_rdata, q0.size() ? q0[0] : 8'h00); end
        if (q0.size() != 0) void'(q0.pop_front());
        got0++;
      end
      if (a_rsp1_valid) begin
        checks++;
        if (q1.size() == 0 || a_rsp1_rdata !== q1[0]) begin errors++; $display("FAIL rr_rsp1 c=%0d: got %h want %h", c, a_rsp1_rdata, q1.size() ? q1[0] : 8'h00); end
        if (q1.size() != 0) void'(q1.pop_front());
        got1++;
      end
      if (a_req0_ready) begin q0.push_back(exp_mem[req0_addr]); n0++; end
      if (a_req1_ready) begin q1.push_back(exp_mem[req1_addr]); n1++; end
      tick();
    end
    checks++; if (got0 != 50 || got1 != 50) begin errors++; $display("FAIL rr_counts: got %0d %0d want 50 50", got0, got1); end
    idle();
  endtask

  task automatic test_backpressure;
    logic e;
    int extra;
    q1.delete();
    idle();
    do_reset();
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 8'h05;
    for (int c = 0; c < 12; c++) begin
      req1_valid = c < 10;
      req1_write = c % 2 == 1;
      req1_addr  = c % 2 == 1 ? 8'(64 + c) : 8'h07;
      req1_wdata = 8'(8'h80 + c);
      if (c >= 10) rsp0_ready = 1'b1;
      #1;
      e = (c == 0 || c == 2 || c == 11);
      checks++; if (a_req0_ready !== e) begin errors++; $display("FAIL bp_req0_ready c=%0d: got %b want %b", c, a_req0_ready, e); end
      if (c < 10) begin
        checks++; if (a_req1_ready !== (c != 0 && c != 2)) begin errors++; $display("FAIL bp_req1_ready c=%0d: got %b want %b", c, a_req1_ready, c != 0 && c != 2); end
      end
      if (c >= 9) begin
        checks++; if (a_rsp0_valid !== 1'b1 || a_rsp0_rdata !== 8'hA5) begin errors++; $display("FAIL bp_rsp0_held c=%0d: got %b %h want 1 a5", c, a_rsp0_valid, a_rsp0_rdata); end
      end
      if (a_rsp1_valid) begin
        checks++;
        if (q1.size() == 0 || a_rsp1_rdata !== q1[0]) begin errors++; $display("FAIL bp_rsp1 c=%0d: got %h want %h", c, a_rsp1_rdata, q1.size() ? q1[0] : 8'h00); end
        if (q1.size() != 0) void'(q1.pop_front());
      end
      if (a_req1_ready) begin
        if (req1_write) exp_mem[req1_addr] = req1_wdata;
        else q1.push_back(exp_mem[req1_addr]);
      end
      tick();
    end
    idle();
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (a_rsp0_valid) begin
        extra++;
        checks++; if (a_rsp0_rdata !== 8'hA5) begin errors++; $display("FAIL bp_resume_data: got %h want a5", a_rsp0_rdata); end
      end
      if (a_rsp1_valid) begin
        checks++;
        if (q1.size() == 0 || a_rsp1_rdata !== q1[0]) begin errors++; $display("FAIL bp_drain_rsp1: got %h want %h", a_rsp1_rdata, q1.size() ? q1[0] : 8'h00); end
        if (q1.size() != 0) void'(q1.pop_front());
      end
      tick();
    end
    checks++; if (extra != 1 || q1.size() != 0) begin errors++; $display("FAIL bp_drain_counts: got %0d %0d want 1 0", extra, q1.size()); end
  endtask

  task automatic test_write_read;
    idle();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 8'h03; req1_wdata = 8'h5A;
    #1;
    checks++; if (a_req1_ready !== 1'b1 || a_we !== 1'b1 || a_din !== 8'h5A) begin errors++; $display("FAIL wr_write_drive: got %b %b %h want 1 1 5a", a_req1_ready, a_we, a_din); end
    tick();
    idle();
    req0_valid = 1'b1; req0_addr = 8'h03;
    #1;
    checks++; if (a_req0_ready !== 1'b1) begin errors++; $display("FAIL wr_read_ready: got %b want 1", a_req0_ready); end
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      checks++; if (a_rsp1_valid !== 1'b0) begin errors++; $display("FAIL wr_no_write_rsp k=%0d: got %b want 0", k, a_rsp1_valid); end
      checks++; if (a_rsp0_valid !== (k == 1)) begin errors++; $display("FAIL wr_rsp0_valid k=%0d: got %b want %b", k, a_rsp0_valid, k == 1); end
      if (k == 1) begin
        checks++; if (a_rsp0_rdata !== 8'h5A) begin errors++; $display("FAIL wr_rsp0_data: got %h want 5a", a_rsp0_rdata); end
      end
      tick();
    end
  endtask

  task automatic test_reset_midop;
    idle();
    do_reset();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_valid = 1'b1; req0_addr = 8'h05;
    tick();
    idle();
    req1_valid = 1'b1; req1_addr = 8'h07;
    tick();
    tick();
    idle();
    #1;
    checks++; if (b_rsp0_valid !== 1'b1 || b_rsp1_valid !== 1'b0) begin errors++; $display("FAIL midop_setup: got %b%b want 10", b_rsp0_valid, b_rsp1_valid); end
    RST = 1'b1;
    #1;
    checks++; if (b_rsp0_valid !== 1'b0 || b_rsp1_valid !== 1'b0 || b_en !== 1'b0) begin errors++; $display("FAIL midop_async_clear: got %b%b%b want 000", b_rsp0_valid, b_rsp1_valid, b_en); end
    checks++; if (a_rsp0_valid !== 1'b0 || a_rsp1_valid !== 1'b0 || a_en !== 1'b0) begin errors++; $display("FAIL midop_async_clear_a: got %b%b%b want 000", a_rsp0_valid, a_rsp1_valid, a_en); end
    tick();
    tick();
    RST = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if ({b_rsp0_valid, b_rsp1_valid, a_rsp0_valid, a_rsp1_valid} !== 4'b0000) begin errors++; $display("FAIL midop_spurious k=%0d: got %b want 0000", k, {b_rsp0_valid, b_rsp1_valid, a_rsp0_valid, a_rsp1_valid}); end
      tick();
    end
    req0_valid = 1'b1; req0_addr = 8'h05;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (b_req0_ready !== (c < 2) || a_req0_ready !== (c < 2)) begin errors++; $display("FAIL midop_credit c=%0d: got %b %b want %b", c, b_req0_ready, a_req0_ready, c < 2); end
      tick();
    end
    idle();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    idle();
    RST = 1'b1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_backpressure();
    test_write_read();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
